// File: rtl/countdown_sequencer.sv
// countdown_sequencer: run-control for a 4-bit down counter.
// Divides the board clock into a count tick, loads a preset on a start edge,
// toggles pause/resume on a pause edge and pulses done on terminal count.
//
// Handshake note: there is no valid/ready traffic here; start and pause are
// debounced synchronous levels and only their rising edges carry meaning.
// An edge is the input high this cycle while its registered copy is low.
module countdown_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PS_W     = 26
) (
    input  logic       clkNexys2,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset,
    output logic [3:0] count,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              start_q;
    logic              pause_q;
    logic [PS_W-1:0]   ps;
    logic              start_e;
    logic              pause_e;
    logic              tick;

    // Rising-edge detection of the button levels and the prescaler terminal.
    always_comb begin
        start_e = start & ~start_q;
        pause_e = pause & ~pause_q;
        tick    = (state == ST_RUN) && (ps == PS_W'(TICK_DIV - 1));
    end

    // Status outputs are decoded straight from the registered state.
    always_comb begin
        running   = (state == ST_RUN);
        paused    = (state == ST_PAUSE);
        state_dbg = state;
    end

    // Sequencer: edge history, prescaler, counter, state and done pulse.
    always_ff @(posedge clkNexys2 or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= 4'hF;
            ps      <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            pause_q <= pause;
            done    <= 1'b0;
            if (start_e) begin
                // A start edge overrides pause and tick from any state.
                count <= preset;
                ps    <= '0;
                if (preset != 4'd0) begin
                    state <= ST_RUN;
                end else begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (tick) begin
                            ps    <= '0;
                            count <= count - 4'd1;
                            if (count == 4'd1) begin
                                // Terminal count beats a coincident pause.
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else if (pause_e) begin
                                state <= ST_PAUSE;
                            end
                        end else begin
                            ps <= ps + PS_W'(1);
                            if (pause_e) begin
                                state <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        // Prescaler phase is kept so paused time is not lost.
                        if (pause_e) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold everything and ignore pause.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV = 4.
module tb_countdown_sequencer;

    localparam int TICK_DIV = 4;
    localparam int PS_W     = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic [3:0] preset;
    logic [3:0] count;
    logic       running;
    logic       paused;
    logic       done;
    logic [1:0] state_dbg;

    int checks;
    int errors;
    int cyc;

    countdown_sequencer #(
        .TICK_DIV(TICK_DIV),
        .PS_W    (PS_W)
    ) dut (
        .clkNexys2(clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .preset   (preset),
        .count    (count),
        .running  (running),
        .paused   (paused),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // One active edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_status(input string tag, input logic [3:0] c, input logic [1:0] s,
                                input logic d);
        check({tag, "_count"}, {28'd0, count}, {28'd0, c});
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, s});
        check({tag, "_running"}, {31'd0, running}, {31'd0, (s == S_RUN)});
        check({tag, "_paused"}, {31'd0, paused}, {31'd0, (s == S_PAUSE)});
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        int k;
        int done_at;
        int pulses;
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        preset = 4'd0;

        // Reset and idle.
        #22;
        check_status("reset", 4'hF, S_IDLE, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_status("idle", 4'hF, S_IDLE, 1'b0);
        end

        // Basic countdown: preset 3.
        preset = 4'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        check_status("basic_k", 4'd3, S_RUN, 1'b0);
        steps(3);
        check_status("basic_k3", 4'd3, S_RUN, 1'b0);
        step();
        check_status("basic_k4", 4'd2, S_RUN, 1'b0);
        steps(4);
        check_status("basic_k8", 4'd1, S_RUN, 1'b0);
        steps(3);
        check_status("basic_k11", 4'd1, S_RUN, 1'b0);
        step();
        check_status("basic_k12", 4'd0, S_DONE, 1'b1);
        step();
        check_status("basic_k13", 4'd0, S_DONE, 1'b0);
        steps(3);
        check_status("basic_hold", 4'd0, S_DONE, 1'b0);

        // Pause/resume: preset 5, unpaused done would be at k+20.
        preset = 4'd5;
        start  = 1'b1;
        step();
        k     = cyc;
        start = 1'b0;
        check_status("pr_k", 4'd5, S_RUN, 1'b0);
        step();
        pause = 1'b1;
        step();
        check_status("pr_pause", 4'd5, S_PAUSE, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step();
            check_status("pr_held", 4'd5, S_PAUSE, 1'b0);
        end
        pause = 1'b0;
        steps(2);
        check_status("pr_gap", 4'd5, S_PAUSE, 1'b0);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_status("pr_resume", 4'd5, S_RUN, 1'b0);
        done_at = -1;
        for (int i = 0; i < 100 && done_at < 0; i++) begin
            step();
            if (done) done_at = cyc - k;
        end
        check("pr_done_edge", done_at, 32);
        check("pr_done_count", {28'd0, count}, 32'd0);
        step();
        check("pr_done_low", {31'd0, done}, 32'd0);

        // Restart and priority: simultaneous start and pause at count 2.
        preset = 4'd4;
        start  = 1'b1;
        step();
        start = 1'b0;
        steps(8);
        check_status("rs_mid", 4'd2, S_RUN, 1'b0);
        preset = 4'd9;
        start  = 1'b1;
        pause  = 1'b1;
        step();
        check_status("rs_load", 4'd9, S_RUN, 1'b0);
        steps(3);
        check_status("rs_ps0", 4'd9, S_RUN, 1'b0);
        step();
        check_status("rs_tick", 4'd8, S_RUN, 1'b0);
        start = 1'b0;
        pause = 1'b0;
        step();

        // Zero preset and held start.
        preset = 4'd0;
        start  = 1'b1;
        step();
        check_status("zero_k", 4'd0, S_DONE, 1'b1);
        step();
        check_status("zero_k1", 4'd0, S_DONE, 1'b0);
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (done) pulses++;
        end
        check("zero_no_repeat", pulses, 0);
        check_status("zero_end", 4'd0, S_DONE, 1'b0);
        start = 1'b0;
        step();

        // Reset mid-run at count 4 with pause held high.
        preset = 4'd6;
        start  = 1'b1;
        step();
        start = 1'b0;
        steps(8);
        check_status("rm_before", 4'd4, S_RUN, 1'b0);
        #2;
        pause = 1'b1;
        reset = 1'b0;
        #1;
        check_status("rm_reset", 4'hF, S_IDLE, 1'b0);
        reset = 1'b1;
        step();
        check_status("rm_pause_ignored", 4'hF, S_IDLE, 1'b0);
        steps(3);
        check_status("rm_idle", 4'hF, S_IDLE, 1'b0);
        pause = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
